ps2_tx_sched: RTL and testbench

- Scan-code scheduler in front of the PS/2 transmit path. Shares one transmitter between NREQ key-event requesters using round-robin arbitration.
- Expands each accepted event into its PS/2 Set-2 byte sequence (optional E0 prefix, optional F0 break prefix, then the code). Presents the bytes one at a time over a valid/ready byte interface to the transmitter wrapper.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_tx_sched_rr_arbiter.sv | 32 +++
 rtl/ps2_tx_sched.sv | 140 ++++++++++++++
 tb/tb_ps2_tx_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 transmit scheduler: state encoding, prefix bytes, width helper.
// ST_GAP is present only when PS2_SCHED_GAP_EN is defined.
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

`ifdef PS2_SCHED_GAP_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_E0   = 3'd1,
      ST_F0   = 3'd2,
      ST_CODE = 3'd3,
      ST_GAP  = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_E0   = 3'd1,
      ST_F0   = 3'd2,
      ST_CODE = 3'd3
   } state_t;
`endif

   function automatic int ps2_idw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ps2_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans req upward from ptr, wrapping, and reports
// the first requester found as a one-hot grant plus its index.
module rr_arbiter
   import ps2_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = ps2_idw(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/ps2_tx_sched.sv
// Round-robin scheduler that expands key events into PS/2 Set-2 byte sequences.
// Optional inter-sequence idle gap when PS2_SCHED_GAP_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for a request; accepts the arbiter winner
// S_E0    | offering the E0 extended prefix
// S_F0    | offering the F0 break prefix
// S_CODE  | offering the latched scan code
// GAP     | enforced idle after the final byte (macro only)
module ps2_tx_sched
   import ps2_pkg::*;
#(
   parameter  int NREQ       = 2,
   parameter  int GAP_CYCLES = 16,
   localparam int IDW        = ps2_idw(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_code,
   input  logic [NREQ-1:0]   req_ext,
   input  logic [NREQ-1:0]   req_brk,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              busy,
   output logic [IDW-1:0]    grant_id
);

   if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_param
      $error("ps2_tx_sched: parameter out of range");
   end

   state_t          state_q, state_d;
   logic [7:0]      code_q;
   logic            brk_q;
   logic [IDW-1:0]  ptr_q, grant_q;

   logic [NREQ-1:0] arb_grant;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic            accept, xfer;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign accept   = (state_q == ST_IDLE) && arb_any;
   assign xfer     = tx_valid && tx_ready;
   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_q;

`ifdef PS2_SCHED_GAP_EN
   localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
   logic [15:0] gap_q;
`endif

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               req_ready = arb_grant;
               if (req_ext[arb_idx])      state_d = ST_E0;
               else if (req_brk[arb_idx]) state_d = ST_F0;
               else                       state_d = ST_CODE;
            end
         end
         ST_E0: begin
            tx_valid = 1'b1;
            tx_data  = PS2_PREFIX_EXT;
            if (tx_ready) state_d = brk_q ? ST_F0 : ST_CODE;
         end
         ST_F0: begin
            tx_valid = 1'b1;
            tx_data  = PS2_PREFIX_BRK;
            if (tx_ready) state_d = ST_CODE;
         end
         ST_CODE: begin
            tx_valid = 1'b1;
            tx_data  = code_q;
`ifdef PS2_SCHED_GAP_EN
            if (tx_ready) state_d = ST_GAP;
`else
            if (tx_ready) state_d = ST_IDLE;
`endif
         end
`ifdef PS2_SCHED_GAP_EN
         ST_GAP: begin
            if (gap_q == 16'd0) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         code_q  <= 8'h00;
         brk_q   <= 1'b0;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            code_q  <= req_code[8*arb_idx +: 8];
            brk_q   <= req_brk[arb_idx];
            grant_q <= arb_idx;
            ptr_q   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
         end
      end
   end

`ifdef PS2_SCHED_GAP_EN
   // Down-counter: loaded on the final byte, GAP exits on terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_q <= 16'd0;
      end else if (state_q == ST_CODE && xfer) begin
         gap_q <= GAP_LOAD;
      end else if (state_q == ST_GAP && gap_q != 16'd0) begin
         gap_q <= gap_q - 16'd1;
      end
   end
`else
   logic unused_xfer;
   assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_ps2_tx_sched.sv
// Directed self-checking bench for ps2_tx_sched (NREQ=2, GAP_CYCLES=4).
// The gap expectation follows PS2_SCHED_GAP_EN.
module tb_ps2_tx_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_code;
   logic [1:0]  req_ext;
   logic [1:0]  req_brk;
   logic [1:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        busy;
   logic        grant_id;

   int vectors = 0;
   int errs    = 0;
   int xfers   = 0;

   always #5 clk = ~clk;

   ps2_tx_sched #(.NREQ(2), .GAP_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_code  (req_code),
      .req_ext   (req_ext),
      .req_brk   (req_brk),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always @(posedge clk) if (!rst && tx_valid && tx_ready) xfers++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      int x0, gap, seen;
      int exp_gap;
      logic [1:0] exp_rr [4];
      logic [7:0] exp_cd [4];
      exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_cd = '{8'h1C, 8'h32, 8'h1C, 8'h32};
`ifdef PS2_SCHED_GAP_EN
      exp_gap = 4;
`else
      exp_gap = 0;
`endif

      rst = 1'b1; req_valid = 2'b00; req_code = 16'h0; req_ext = 2'b00; req_brk = 2'b00;
      tx_ready = 1'b1;
      step(); step();
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      rst = 1'b0;
      step();

      // plain make 1C from requester 0
      x0 = xfers;
      req_valid = 2'b01; req_code = 16'h001C;
      #1 chk("make_req_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00;
      #1;
      chk("make_valid", 32'(tx_valid), 1);
      chk("make_data", 32'(tx_data), 32'h1C);
      chk("make_req_ready_off", 32'(req_ready), 0);
      step();
      chk("make_idle_busy", 32'(busy), 0);
      chk("make_idle_valid", 32'(tx_valid), 0);
      chk("make_xfers", 32'(xfers - x0), 1);

      // extended break 75 from requester 1
      x0 = xfers;
      req_valid = 2'b10; req_code = 16'h7500; req_ext = 2'b10; req_brk = 2'b10;
      #1 chk("xbrk_req_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = 2'b00; req_ext = 2'b00; req_brk = 2'b00;
      #1;
      chk("xbrk_b0", 32'(tx_data), 32'hE0);
      chk("xbrk_grant", 32'(grant_id), 1);
      step();
      chk("xbrk_b1", 32'(tx_data), 32'hF0);
      step();
      chk("xbrk_b2", 32'(tx_data), 32'h75);
      chk("xbrk_b2_valid", 32'(tx_valid), 1);
      step();
      chk("xbrk_done", 32'(busy), 0);
      chk("xbrk_xfers", 32'(xfers - x0), 3);

      // backpressure on break 1C: requester 0 wins since pointer wrapped to 0
      x0 = xfers;
      tx_ready = 1'b0;
      req_valid = 2'b01; req_code = 16'h001C; req_brk = 2'b01;
      #1 chk("bp_req_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00; req_brk = 2'b00;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_hold", {23'd0, tx_valid, tx_data}, 32'h1F0);
         step();
      end
      tx_ready = 1'b1;
      #1 chk("bp_hold6", {23'd0, tx_valid, tx_data}, 32'h1F0);
      step();
      chk("bp_code", {23'd0, tx_valid, tx_data}, 32'h11C);
      step();
      chk("bp_xfers", 32'(xfers - x0), 2);

      // reset while waiting in S_F0
      tx_ready = 1'b0;
      req_valid = 2'b10; req_code = 16'h2200; req_brk = 2'b10;
      step();
      req_valid = 2'b00; req_brk = 2'b00;
      #1 chk("rmid_in_f0", {23'd0, tx_valid, tx_data}, 32'h1F0);
      chk("rmid_grant_pre", 32'(grant_id), 1);
      x0 = xfers;
      rst = 1'b1;
      step();
      chk("rmid_valid", 32'(tx_valid), 0);
      chk("rmid_busy", 32'(busy), 0);
      chk("rmid_grant", 32'(grant_id), 0);
      rst = 1'b0; tx_ready = 1'b1;
      step(); step(); step();
      chk("rmid_no_bytes", 32'(xfers - x0), 0);

      // fairness: both requesters continuously valid
      req_valid = 2'b11; req_code = 16'h321C;
      for (int s = 0; s < 4; s++) begin
         seen = 0;
         for (int c = 0; c < 12 && seen == 0; c++) begin
            #1 if (req_ready != 2'b00) seen = 1; else step();
         end
         chk("fair_wait", 32'(seen), 1);
         chk("fair_order", 32'(req_ready), 32'(exp_rr[s]));
         step();
         #1 chk("fair_code", 32'(tx_data), 32'(exp_cd[s]));
         chk("fair_grant", 32'(grant_id), (s % 2));
         step();
      end
      req_valid = 2'b00;
      step(); step();

      // back-to-back makes from requester 0: count idle-but-busy cycles between them
      rst = 1'b1; step(); rst = 1'b0;
      req_valid = 2'b01; req_code = 16'h0016;
      #1 chk("gap_first_accept", 32'(req_ready), 32'h1);
      step();
      #1 chk("gap_first_code", {23'd0, tx_valid, tx_data}, 32'h116);
      step();
      gap = 0; seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         #1;
         if (req_ready != 2'b00) seen = 1;
         else begin
            if (busy && !tx_valid) gap++;
            step();
         end
      end
      chk("gap_second_accept", 32'(seen), 1);
      chk("gap_cycles", 32'(gap), 32'(exp_gap));
      req_valid = 2'b00;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
